// File: rtl/eth_clk_pkg.sv
// Shared types for the multi-rate RGMII TX clock generator.
package eth_clk_pkg;

   // Requested/applied link speed; both 2'b10 and 2'b11 mean 1000M.
   typedef enum logic [1:0] {
      SPEED_10M    = 2'b00,
      SPEED_100M   = 2'b01,
      SPEED_1G     = 2'b10,
      SPEED_1G_ALT = 2'b11
   } eth_speed_e;

   // Sequencer states of the clock generator.
   typedef enum logic [1:0] {
      ST_RST   = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_QUIET = 2'b11
   } clk_state_e;

   // Maps a speed to its gtx half-period in reference clock cycles.
   function automatic int halfPeriod(eth_speed_e speed, int half1g, int half100m, int half10m);
      case (speed)
         SPEED_10M:  return half10m;
         SPEED_100M: return half100m;
         default:    return half1g;
      endcase
   endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear wins over up on the same cycle.
module bsg_counter_clear_up #(
   parameter int max_val_p  = 8,
   parameter int init_val_p = 0,
   localparam int ptr_width_lp = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clear_i,
   input  logic                    up_i,
   output logic [ptr_width_lp-1:0] count_o
);

   logic [ptr_width_lp-1:0] r_count;

   // Count register: clear restarts from zero, otherwise add one when up_i is set.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_count <= ptr_width_lp'(init_val_p);
      end else if (clear_i) begin
         r_count <= '0;
      end else if (up_i) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count_o = r_count;

endmodule

// File: rtl/eth_tx_clk_gen_multirate.sv
// Multi-rate RGMII TX clock generator: gtx clock, lagged PHY clock and
// a stretched gtx-domain reset, with glitch-free run-time speed changes.
module eth_tx_clk_gen_multirate
   import eth_clk_pkg::*;
#(
   parameter int         half_1g_p      = 1,
   parameter int         half_100m_p    = 5,
   parameter int         half_10m_p     = 50,
   parameter logic [1:0] init_speed_p   = 2'b10,
   parameter int         reset_cycles_p = 8,
   parameter int         quiet_cycles_p = 4,
   parameter int         phy_lag_p      = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] speed_i,
   input  logic       speed_v_i,
   output logic       speed_ready_o,
   output logic [1:0] speed_o,
   output logic       locked_o,
   output logic       gtx_clk_r_o,
   output logic       phy_tx_clk_r_o,
   output logic       gtx_rst_r_o
);

   localparam int CntW       = (half_10m_p > 1) ? $clog2(half_10m_p) : 1;
   localparam int StretchMax = (reset_cycles_p > quiet_cycles_p) ? reset_cycles_p : quiet_cycles_p;
   localparam int StretchW   = $clog2(StretchMax + 1);
   localparam logic [StretchW-1:0] RstLast   = StretchW'(reset_cycles_p - 1);
   localparam logic [StretchW-1:0] QuietLast = StretchW'(quiet_cycles_p - 1);

   clk_state_e            r_state;
   clk_state_e            w_stateNext;
   eth_speed_e            r_mode;
   eth_speed_e            r_pend;
   logic [CntW-1:0]       r_cnt;
   logic                  r_gtx;
   logic [phy_lag_p-1:0]  r_phySr;
   logic [CntW-1:0]       w_halfM1;
   logic                  w_toggle;
   logic                  w_handshake;
   logic                  w_stretchClear;
   logic [StretchW-1:0]   w_stretch;

   assign w_halfM1       = CntW'(halfPeriod(r_mode, half_1g_p, half_100m_p, half_10m_p) - 1);
   assign w_toggle       = (r_cnt == w_halfM1);
   assign w_handshake    = speed_v_i && (r_state == ST_RUN);
   assign w_stretchClear = (w_stateNext != r_state);

   // Shared stretch counter times both the reset hold and the quiet gap; cleared on every state entry.
   bsg_counter_clear_up #(
      .max_val_p  (StretchMax),
      .init_val_p (0)
   ) u_stretch (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (w_stretchClear),
      .up_i    (1'b1),
      .count_o (w_stretch)
   );

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= ST_RST;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state decode; a drain whose clock is already low leaves at once so the high phase is never cut.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_RST: begin
            if (w_stretch == RstLast) w_stateNext = ST_RUN;
         end
         ST_RUN: begin
            if (w_handshake) w_stateNext = r_gtx ? ST_DRAIN : ST_QUIET;
         end
         ST_DRAIN: begin
            if (!r_gtx || w_toggle) w_stateNext = ST_QUIET;
         end
         ST_QUIET: begin
            if (w_stretch == QuietLast) w_stateNext = ST_RST;
         end
         default: w_stateNext = ST_RST;
      endcase
   end

   // Phase counter and gtx toggle; quiet forces both low, and a drain that has already fallen holds low.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_cnt <= '0;
         r_gtx <= 1'b0;
      end else if (r_state == ST_QUIET) begin
         r_cnt <= '0;
         r_gtx <= 1'b0;
      end else if ((r_state == ST_DRAIN) && !r_gtx) begin
         r_cnt <= r_cnt;
         r_gtx <= 1'b0;
      end else if (w_toggle) begin
         r_cnt <= '0;
         r_gtx <= ~r_gtx;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // PHY clock is gtx delayed through a phy_lag_p-deep shift register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_phySr <= '0;
      end else begin
         r_phySr <= phy_lag_p'({r_phySr, r_gtx});
      end
   end

   // Captures an accepted request and applies it only when leaving the quiet gap.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_mode <= eth_speed_e'(init_speed_p);
         r_pend <= eth_speed_e'(init_speed_p);
      end else begin
         if (w_handshake) begin
            r_pend <= eth_speed_e'(speed_i);
         end
         if ((r_state == ST_QUIET) && (w_stateNext == ST_RST)) begin
            r_mode <= r_pend;
         end
      end
   end

   assign gtx_clk_r_o    = r_gtx;
   assign phy_tx_clk_r_o = r_phySr[phy_lag_p-1];
   assign gtx_rst_r_o    = (r_state == ST_RST) || (r_state == ST_QUIET);
   assign locked_o       = (r_state == ST_RUN);
   assign speed_ready_o  = (r_state == ST_RUN);
   assign speed_o        = r_mode;

endmodule

// File: tb/tb_eth_tx_clk_gen_multirate.sv
// Directed scoreboard bench for eth_tx_clk_gen_multirate with default parameters.
module tb_eth_tx_clk_gen_multirate;

   logic       clk;
   logic       resetIn;
   logic [1:0] speedIn;
   logic       speedValid;
   logic       speedReady;
   logic [1:0] speedOut;
   logic       locked;
   logic       gtxClk;
   logic       phyClk;
   logic       gtxRst;

   int nAsserts = 0;
   int nFails   = 0;

   typedef struct {
      string      tag;
      int         sel;
      logic [1:0] val;
   } exp_t;

   exp_t expQ[$];

   eth_tx_clk_gen_multirate dut (
      .clk_i          (clk),
      .reset_i        (resetIn),
      .speed_i        (speedIn),
      .speed_v_i      (speedValid),
      .speed_ready_o  (speedReady),
      .speed_o        (speedOut),
      .locked_o       (locked),
      .gtx_clk_r_o    (gtxClk),
      .phy_tx_clk_r_o (phyClk),
      .gtx_rst_r_o    (gtxRst)
   );

   // Free-running 100 MHz reference clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected gtx level after global edge m of the scripted run.
   function automatic logic expGtx(int m);
      if (m <= 0)   return 1'b0;
      if (m <= 13)  return 1'(m % 2);
      if (m <= 23)  return 1'b0;
      if (m <= 48)  return (((m - 24) / 5) % 2) == 0;
      if (m <= 102) return 1'b0;
      if (m <= 259) return (((m - 103) / 50) % 2) == 0;
      return 1'((m - 260) % 2);
   endfunction

   // Expected gtx-domain reset after edge m.
   function automatic logic expRst(int m);
      return (m < 8) || (m >= 15 && m <= 26) || (m >= 49 && m <= 60) || (m >= 256 && m <= 267);
   endfunction

   // Expected lock (and ready) after edge m.
   function automatic logic expLocked(int m);
      return !((m < 8) || (m >= 14 && m <= 26) || (m >= 47 && m <= 60) ||
               (m >= 256 && m <= 267) || (m == 276));
   endfunction

   // Expected applied speed after edge m.
   function automatic logic [1:0] expSpeed(int m);
      if (m < 19)  return 2'b10;
      if (m < 53)  return 2'b01;
      if (m < 260) return 2'b00;
      return 2'b11;
   endfunction

   function automatic logic [1:0] observe(int sel);
      case (sel)
         0:       return {1'b0, gtxClk};
         1:       return {1'b0, phyClk};
         2:       return {1'b0, gtxRst};
         3:       return {1'b0, locked};
         4:       return {1'b0, speedReady};
         default: return speedOut;
      endcase
   endfunction

   task automatic pushExp(input string tag, input int sel, input logic [1:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      expQ.push_back(e);
   endtask

   task automatic pushAll(input string pfx, input logic g, input logic p, input logic r,
                          input logic l, input logic [1:0] s);
      pushExp({pfx, " gtx"},    0, {1'b0, g});
      pushExp({pfx, " phy"},    1, {1'b0, p});
      pushExp({pfx, " rst"},    2, {1'b0, r});
      pushExp({pfx, " locked"}, 3, {1'b0, l});
      pushExp({pfx, " ready"},  4, {1'b0, l});
      pushExp({pfx, " speed"},  5, s);
   endtask

   task automatic checkOutput();
      exp_t e;
      logic [1:0] obs;
      while (expQ.size() > 0) begin
         e   = expQ.pop_front();
         obs = observe(e.sel);
         nAsserts++;
         assert (obs === e.val) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] s);
      speedValid = v;
      speedIn    = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic runEdges(input int first, input int last);
      for (int m = first; m <= last; m++) begin
         tick();
         pushAll($sformatf("edge%0d", m), expGtx(m), expGtx(m - 1), expRst(m),
                 expLocked(m), expSpeed(m));
         checkOutput();
      end
   endtask

   initial begin
      resetIn = 1'b1;
      applyStimulus(1'b0, 2'b00);
      #12;
      $display("[TB] checking reset values");
      pushAll("reset", 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
      checkOutput();
      @(negedge clk);
      resetIn = 1'b0;

      $display("[TB] 1000M start-up");
      runEdges(1, 13);

      $display("[TB] 1000M to 100M while gtx high");
      applyStimulus(1'b1, 2'b01);
      runEdges(14, 14);
      applyStimulus(1'b0, 2'b01);
      runEdges(15, 46);

      $display("[TB] 100M to 10M mid high phase, request held through quiet");
      applyStimulus(1'b1, 2'b00);
      runEdges(47, 47);
      applyStimulus(1'b1, 2'b01);
      runEdges(48, 60);
      applyStimulus(1'b0, 2'b01);
      runEdges(61, 255);

      $display("[TB] 10M to speed 11 while gtx low");
      applyStimulus(1'b1, 2'b11);
      runEdges(256, 256);
      applyStimulus(1'b0, 2'b11);
      runEdges(257, 275);

      $display("[TB] reset during drain");
      applyStimulus(1'b1, 2'b00);
      runEdges(276, 276);
      #2;
      resetIn = 1'b1;
      #1;
      pushAll("midDrainReset", 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
      checkOutput();
      applyStimulus(1'b0, 2'b00);
      tick();
      tick();
      @(negedge clk);
      resetIn = 1'b0;
      runEdges(1, 12);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
